// File: rtl/io_responder_pkg.sv
// Shared constants for the CPU-facing I/O responder:
// register addresses and the seven-segment glyph table.
package io_responder_pkg;

  localparam logic [7:0] ADDR_LED  = 8'h60;
  localparam logic [7:0] ADDR_SW   = 8'h70;
  localparam logic [7:0] ADDR_BTN  = 8'h74;
  localparam logic [7:0] ADDR_FLAG = 8'h78;
  localparam logic [7:0] ADDR_SEG  = 8'h80;

  // {dp,g..a}, active low, dp off; entry 0 is the rightmost byte
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/io_responder_btn_debounce.sv
// One push button: two-flop synchronizer, hold counter,
// accepted level, and a pulse on the edge it rises.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  logic        meta_q, sync_q;
  logic        stable_q, stable_d;
  logic [19:0] cnt_q, cnt_d;

  // accept the synced level once it has differed long enough
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == DEBOUNCE_CYC - 20'd1) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // synchronizer, counter and accepted level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= btn_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped LEDs, switches, buttons and a
// multiplexed eight-digit seven-segment display.
module io_responder
  import io_responder_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1000000,
  parameter logic [16:0] SCAN_DIV     = 17'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ioRead,
  input  logic        ioWrite,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic [7:0]  addr_lo,
  input  logic [31:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic [15:0] sw,
  input  logic [4:0]  btn,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_data
);

  logic [15:0] led_q, led_d;
  logic [31:0] seg_val_q, seg_val_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic [4:0]  flag_q, flag_d;
  logic [16:0] scan_q, scan_d;
  logic [2:0]  idx_q, idx_d;
  logic [4:0]  stable, rise;
  logic        wr_en, rd_en, flag_clr;
  logic [3:0]  nib;

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i])
    );
  end

  assign wr_en    = ioWrite & LEDCtrl;
  assign rd_en    = ioRead & SwitchCtrl;
  assign flag_clr = rd_en & (addr_lo == ADDR_FLAG);

  // write decode, sticky flags, and scan timing
  always_comb begin
    led_d     = led_q;
    seg_val_d = seg_val_q;
    if (wr_en && addr_lo == ADDR_LED) led_d = io_wdata[15:0];
    if (wr_en && addr_lo == ADDR_SEG) seg_val_d = io_wdata;
    flag_d = (flag_clr ? 5'b0 : flag_q) | rise;
    scan_d = scan_q + 17'd1;
    idx_d  = idx_q;
    if (scan_q == SCAN_DIV - 17'd1) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end
  end

  // architectural state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q     <= '0;
      seg_val_q <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      flag_q    <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
    end else begin
      led_q     <= led_d;
      seg_val_q <= seg_val_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      flag_q    <= flag_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
    end
  end

  // read mux from registered state
  always_comb begin
    io_rdata = 16'h0000;
    if (rd_en) begin
      unique case (1'b1)
        addr_lo == ADDR_SW:   io_rdata = sw_sync_q;
        addr_lo == ADDR_BTN:  io_rdata = {11'b0, stable};
        addr_lo == ADDR_FLAG: io_rdata = {11'b0, flag_q};
        default:              io_rdata = 16'h0000;
      endcase
    end
  end

  assign nib      = seg_val_q[{idx_q, 2'b00} +: 4];
  assign led      = led_q;
  assign seg_an   = ~(8'b1 << idx_q);
  assign seg_data = HEX_SEG[nib];

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter: DEBOUNCE_CYC, 20'd1000000, cycles a synchronized button level must hold before it is accepted.
REQ-002 Parameter: SCAN_DIV, 17'd100000, clock cycles per seven-segment digit slot.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ioRead  in  1  CPU I/O read strobe, one cycle per access.
REQ-006 ioWrite  in  1  CPU I/O write strobe, one cycle per access.
REQ-007 LEDCtrl  in  1  output-region chip select, active high.
REQ-008 SwitchCtrl  in  1  input-region chip select, active high.
REQ-009 addr_lo  in  8  address bits [7:0].
REQ-010 io_wdata  in  32  CPU write data.
REQ-011 io_rdata  out  16  read data to CPU.
REQ-012 sw  in  16  asynchronous slide switches.
REQ-013 btn  in  5  asynchronous push buttons, active high.
REQ-014 led  out  16  LED drive, active high.
REQ-015 seg_an  out  8  digit anodes, active-low one-hot.
REQ-016 seg_data  out  8  segments {dp,g..a}, active low.

Function
REQ-017 Write map: ioWrite&LEDCtrl&addr_lo==8'h60 -> led<=io_wdata[15:0] next edge; ==8'h80 -> seg_val<=io_wdata[31:0] next edge; other addresses or missing chip select -> no state change.
REQ-018 Read map (combinational, from registered state): ioRead&SwitchCtrl with addr_lo 8'h70 -> sw_sync; 8'h74 -> {11'b0,btn_stable}; 8'h78 -> {11'b0,btn_flag}; any other case -> 16'h0000.
REQ-019 sw: two-flop synchronizer per bit; read value lags pins by 2 cycles.
REQ-020 btn: two-flop synchronizer, then per-bit counter; btn_stable[i] takes the synchronized value after it differs from btn_stable[i] for DEBOUNCE_CYC consecutive cycles; any return to equality clears the counter.
REQ-021 btn_flag[i] sets on the cycle btn_stable[i] rises 0->1; sticky.
REQ-022 Read of 8'h78 clears btn_flag at the next edge (read-to-clear); a rise in the same cycle as the clearing read leaves that bit set.
REQ-023 Scan counter counts 0..SCAN_DIV-1 and wraps; at wrap, digit index 0..7 increments, 7 wraps to 0.
REQ-024 seg_an = ~(8'b1<<index); seg_data = hex pattern of seg_val[4*index+3:4*index], dp bit 1 (off).
REQ-025 Simultaneous ioRead and ioWrite: both honoured independently.
REQ-026 led and seg_val hold until rewritten or reset.

Reset
REQ-027 rst_n low at an edge: led=0, seg_val=0, sync flops=0, btn_stable=0, btn_flag=0, debounce counters=0, scan counter=0, index=0.
REQ-028 During and after reset: seg_an=8'hFE, seg_data=8'hC0 (digit 0 showing "0"); io_rdata follows REQ-018 from reset state.
REQ-029 Reset mid-debounce discards partial count; reset coincident with a write discards the write.

Structure
REQ-030 Shared package: address constants (8'h60, 8'h70, 8'h74, 8'h78, 8'h80) and the 16-entry hex-to-segment table.
REQ-031 One sub-module, btn_debounce (synchronizer + counter + stable bit), instantiated five times.

Verification
REQ-032 ioWrite=1, LEDCtrl=1, addr_lo=8'h60, io_wdata=32'h1234ABCD -> led=16'hABCD next edge; same with LEDCtrl=0 -> led unchanged.
REQ-033 sw=16'h5A5A, then ioRead, SwitchCtrl, addr_lo=8'h70 at cycles 1 and 3 -> io_rdata 16'h0000 then 16'h5A5A.
REQ-034 DEBOUNCE_CYC=4, btn[2] pulse of 3 cycles -> btn_stable stays 0; hold 10 cycles -> read 8'h74 = 16'h0004, read 8'h78 = 16'h0004.
REQ-035 Read 8'h78 in the cycle btn[0] stable rises, btn[2] flag already set -> after edge flag = 5'b00001.
REQ-036 SCAN_DIV=2, seg_val=32'h0000_00F1 -> index 0: seg_an=8'hFE, seg_data=8'hF9; index 1: seg_an=8'hFD, seg_data=8'h8E; index wraps 7->0 after 16 cycles.
REQ-037 rst_n=0 for one edge after writes -> led=0, seg_an=8'hFE, all reads 16'h0000 except sw after 2 cycles.
